bin2bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits, one shift per clock. It sits directly upstream of the per-digit `bcd7seg` decoders on the board display path. Each 4-bit digit of its registered output drives one `bcd7seg` instance. A valid/ready handshake on both sides lets a counter, switch sampler or CPU-side MMIO register feed it without glitching the display.

---
 rtl/bin2bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_add3.sv | 19 +
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit adjust threshold and an elaboration-time power helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // 10^n, used only to validate the digit count against the input width
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Per-digit conditional +3, truncated to 4 bits
  always_comb begin
    if (d >= BCD_ADJ_THRESH) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift per clock, with valid/ready
// on both sides and a separate output register so partial digits never show.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int CW = $clog2(W + 1);

  if (pow10(DIGITS) <= ((64'd1 << W) - 64'd1)) begin : g_digits_too_few
    $fatal(1, "bin2bcd_seq: DIGITS too small to hold 2^W-1");
  end

  state_t                state_r;
  state_t                next_state_s;
  logic [CW-1:0]         cnt_r;
  logic [W-1:0]          bin_r;
  logic [4*DIGITS-1:0]   scratch_r;
  logic [4*DIGITS-1:0]   adj_s;
  logic [4*DIGITS-1:0]   scratch_nxt_s;
  logic [W-1:0]          bin_nxt_s;
  logic [4*DIGITS-1:0]   out_bcd_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d (scratch_r[4*g +: 4]),
      .q (adj_s[4*g +: 4])
    );
  end

  // Adjusted digits and binary MSB shift together as one wide register
  assign scratch_nxt_s = {adj_s[4*DIGITS-2:0], bin_r[W-1]};
  assign bin_nxt_s     = {bin_r[W-2:0], 1'b0};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CW'(1)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, shift while converting, publish on last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      bin_r     <= '0;
      scratch_r <= '0;
      out_bcd_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            bin_r     <= in_bin;
            scratch_r <= '0;
            cnt_r     <= CW'(W);
          end
        end
        SHIFT: begin
          bin_r     <= bin_nxt_s;
          scratch_r <= scratch_nxt_s;
          cnt_r     <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            out_bcd_r <= scratch_nxt_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_bcd   = out_bcd_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a driver queues decimal-digit expectations,
// an independent monitor checks every output handshake against them.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;

  int compared;
  int mismatched;
  int cyc;
  int acc_cyc;
  int prev_acc;
  logic [11:0] expq[$];

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by plain arithmetic
  function automatic logic [11:0] bcd_model(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present v until accepted; optionally randomize gaps and out_ready
  task automatic send(input logic [7:0] v, input bit rnd);
    int n;
    @(negedge clk);
    if (rnd) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_bin   = v;
    n = 0;
    while (!in_ready && n < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for value %0d", v);
      in_valid = 1'b0;
    end else begin
      expq.push_back(bcd_model(int'(v)));
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);
  endtask

  // Monitor: a handshake seen away from the edge completes on the next edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got %0h expected no output", out_bcd);
        end else begin
          chk("result", 32'(out_bcd), 32'(expq.pop_front()));
        end
      end
    end
  end

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_bin     = 8'd0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then idle hold
    @(negedge clk);
    chk("rst_out_bcd", 32'(out_bcd), 32'h000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("idle_out_bcd", 32'(out_bcd), 32'h000);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // 255 latency: negedge k follows accept edge t+k
    send(8'd255, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk("lat_out_valid_low", 32'(out_valid), 32'd0);
        chk("lat_in_ready_low", 32'(in_ready), 32'd0);
        chk("lat_out_bcd_hold", 32'(out_bcd), 32'h000);
      end else if (k == 8) begin
        chk("lat_out_valid_high", 32'(out_valid), 32'd1);
        chk("lat_in_ready_done", 32'(in_ready), 32'd0);
        chk("lat_out_bcd_255", 32'(out_bcd), 32'h255);
      end else begin
        chk("lat_in_ready_back", 32'(in_ready), 32'd1);
        chk("lat_out_valid_drop", 32'(out_valid), 32'd0);
      end
    end

    // Full sweep back to back, 10 cycles per conversion
    for (int v = 0; v < 256; v++) begin
      send(8'(v), 1'b0);
      if (v > 0) chk("sweep_period", 32'(acc_cyc - prev_acc), 32'd10);
      prev_acc = acc_cyc;
    end
    drain();

    // Backpressure with ignored input pulses
    out_ready = 1'b0;
    send(8'd42, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i == 5 || i == 12);
      in_bin   = 8'd7;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_bcd", 32'(out_bcd), 32'h042);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(8'd58, 1'b0);
    drain();

    // Reset during shift 4, prior result must hold until then
    send(8'd13, 1'b0);
    send(8'd200, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("abort_hold_013", 32'(out_bcd), 32'h013);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (expq.size() != 0) void'(expq.pop_back());
    chk("abort_out_bcd", 32'(out_bcd), 32'h000);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    chk("abort_no_result", 32'(out_valid), 32'd0);

    // Input not re-sampled after acceptance
    send(8'd128, 1'b0);
    in_bin = 8'd1;
    drain();

    // Randomized values with random gaps and backpressure
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
